// File: rtl/pipe_ctrl_tracker_pkg.sv
// Shared constants for the pipeline control tracker: ALU control encodings,
// forwarding-select encodings and the branch-resolution helper.
package pipe_ctrl_tracker_pkg;

    // ALU control encodings produced by the main decoder
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;

    // Forwarding-mux selects for the EX-stage ALU operands
    localparam logic [1:0] FWD_REG = 2'b00;  // value read from the register file
    localparam logic [1:0] FWD_MEM = 2'b10;  // result held in EX/MEM
    localparam logic [1:0] FWD_WB  = 2'b01;  // result held in MEM/WB

    // BEQ takes on zero, BNE takes on non-zero
    function automatic logic branch_taken(input logic is_branch,
                                          input logic is_bne,
                                          input logic zero);
        return is_branch & (is_bne ? ~zero : zero);
    endfunction

endpackage

// File: rtl/pipe_ctrl_tracker_if.sv
// Decoder-side inputs and datapath-side control outputs of the tracker.
// master = decoder/datapath environment, slave = the tracker itself.
interface pipe_ctrl_tracker_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              id_RegDst;
    logic              id_Branch;
    logic              id_bne;
    logic              id_MemRead;
    logic              id_MemWrite;
    logic              id_MemToReg;
    logic              id_ALUSrc;
    logic              id_RegWrite;
    logic [1:0]        id_ALUcntrl;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic              ex_Zero;

    logic              stall;
    logic              flush_ifid;
    logic              pc_src;
    logic              ex_ALUSrc;
    logic [1:0]        ex_ALUcntrl;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic              mem_MemRead;
    logic              mem_MemWrite;
    logic              wb_RegWrite;
    logic              wb_MemToReg;
    logic [REG_AW-1:0] wb_dst;
    logic [1:0]        fwdA;
    logic [1:0]        fwdB;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_RegDst, id_Branch, id_bne, id_MemRead, id_MemWrite, id_MemToReg,
               id_ALUSrc, id_RegWrite, id_ALUcntrl, id_rs, id_rt, id_rd, ex_Zero,
        input  stall, flush_ifid, pc_src, ex_ALUSrc, ex_ALUcntrl, ex_rs, ex_rt,
               mem_MemRead, mem_MemWrite, wb_RegWrite, wb_MemToReg, wb_dst,
               fwdA, fwdB, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_RegDst, id_Branch, id_bne, id_MemRead, id_MemWrite, id_MemToReg,
               id_ALUSrc, id_RegWrite, id_ALUcntrl, id_rs, id_rt, id_rd, ex_Zero,
        output stall, flush_ifid, pc_src, ex_ALUSrc, ex_ALUcntrl, ex_rs, ex_rt,
               mem_MemRead, mem_MemWrite, wb_RegWrite, wb_MemToReg, wb_dst,
               fwdA, fwdB, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_ctrl_tracker_fwd_unit.sv
// Forwarding unit: picks the freshest producer for each EX-stage source operand.
// EX/MEM beats MEM/WB; register $0 is never forwarded.
module pipe_fwd_unit
    import pipe_ctrl_tracker_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_ex_rs,
    input  logic [REG_AW-1:0] i_ex_rt,
    input  logic              i_mem_RegWrite,
    input  logic [REG_AW-1:0] i_mem_dst,
    input  logic              i_wb_RegWrite,
    input  logic [REG_AW-1:0] i_wb_dst,
    output logic [1:0]        o_fwdA,
    output logic [1:0]        o_fwdB
);

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                           input logic              mem_we,
                                           input logic [REG_AW-1:0] mem_dst,
                                           input logic              wb_we,
                                           input logic [REG_AW-1:0] wb_dst);
        if (mem_we && (mem_dst != '0) && (mem_dst == src)) return FWD_MEM;
        if (wb_we && (wb_dst != '0) && (wb_dst == src))    return FWD_WB;
        return FWD_REG;
    endfunction

    // Operand A follows rs, operand B follows rt
    always_comb begin
        o_fwdA = FWD_REG;
        o_fwdB = FWD_REG;
        o_fwdA = fwd_sel(i_ex_rs, i_mem_RegWrite, i_mem_dst, i_wb_RegWrite, i_wb_dst);
        o_fwdB = fwd_sel(i_ex_rt, i_mem_RegWrite, i_mem_dst, i_wb_RegWrite, i_wb_dst);
    end

endmodule

// File: rtl/pipe_ctrl_tracker.sv
// Pipeline control tracker: carries decoded control ID->EX->MEM->WB, inserts
// load-use stalls, resolves BEQ/BNE in EX, and counts stall/flush events.
module pipe_ctrl_tracker
    import pipe_ctrl_tracker_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic               clock,
    input  logic               reset,
    pipe_ctrl_tracker_if.slave bus
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic              r_RegDst_p0, r_Branch_p0, r_bne_p0, r_MemRead_p0;
    logic              r_MemWrite_p0, r_MemToReg_p0, r_ALUSrc_p0, r_RegWrite_p0;
    logic [1:0]        r_ALUcntrl_p0;
    logic [REG_AW-1:0] r_rs_p0, r_rt_p0, r_rd_p0;

    logic              r_MemRead_p1, r_MemWrite_p1, r_MemToReg_p1, r_RegWrite_p1;
    logic [REG_AW-1:0] r_dst_p1;

    logic              r_MemToReg_p2, r_RegWrite_p2;
    logic [REG_AW-1:0] r_dst_p2;

    logic [CNT_W-1:0]  r_stall_cnt, r_flush_cnt;

    logic [REG_AW-1:0] w_ex_dst;
    logic              w_pc_src, w_stall;
    logic [1:0]        w_fwdA, w_fwdB;

    assign w_ex_dst = r_RegDst_p0 ? r_rd_p0 : r_rt_p0;
    assign w_pc_src = branch_taken(r_Branch_p0, r_bne_p0, bus.ex_Zero);
    // A taken branch squashes the waiting consumer, so it never stalls as well
    assign w_stall  = r_MemRead_p0 && (w_ex_dst != '0) &&
                      ((w_ex_dst == bus.id_rs) || (w_ex_dst == bus.id_rt)) && !w_pc_src;

    // ---- ID/EX boundary: load decoded control, or a bubble on stall/redirect
    always_ff @(posedge clock) begin
        if (!reset || w_pc_src || w_stall) begin
            r_RegDst_p0   <= 1'b0;
            r_Branch_p0   <= 1'b0;
            r_bne_p0      <= 1'b0;
            r_MemRead_p0  <= 1'b0;
            r_MemWrite_p0 <= 1'b0;
            r_MemToReg_p0 <= 1'b0;
            r_ALUSrc_p0   <= 1'b0;
            r_RegWrite_p0 <= 1'b0;
            r_ALUcntrl_p0 <= ALU_ADD;
            r_rs_p0       <= '0;
            r_rt_p0       <= '0;
            r_rd_p0       <= '0;
        end else begin
            r_RegDst_p0   <= bus.id_RegDst;
            r_Branch_p0   <= bus.id_Branch;
            r_bne_p0      <= bus.id_bne;
            r_MemRead_p0  <= bus.id_MemRead;
            r_MemWrite_p0 <= bus.id_MemWrite;
            r_MemToReg_p0 <= bus.id_MemToReg;
            r_ALUSrc_p0   <= bus.id_ALUSrc;
            r_RegWrite_p0 <= bus.id_RegWrite;
            r_ALUcntrl_p0 <= bus.id_ALUcntrl;
            r_rs_p0       <= bus.id_rs;
            r_rt_p0       <= bus.id_rt;
            r_rd_p0       <= bus.id_rd;
        end
    end

    // ---- EX/MEM boundary: always advances, a bubble carries zero control
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_MemRead_p1  <= 1'b0;
            r_MemWrite_p1 <= 1'b0;
            r_MemToReg_p1 <= 1'b0;
            r_RegWrite_p1 <= 1'b0;
            r_dst_p1      <= '0;
        end else begin
            r_MemRead_p1  <= r_MemRead_p0;
            r_MemWrite_p1 <= r_MemWrite_p0;
            r_MemToReg_p1 <= r_MemToReg_p0;
            r_RegWrite_p1 <= r_RegWrite_p0;
            r_dst_p1      <= w_ex_dst;
        end
    end

    // ---- MEM/WB boundary: always advances
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_MemToReg_p2 <= 1'b0;
            r_RegWrite_p2 <= 1'b0;
            r_dst_p2      <= '0;
        end else begin
            r_MemToReg_p2 <= r_MemToReg_p1;
            r_RegWrite_p2 <= r_RegWrite_p1;
            r_dst_p2      <= r_dst_p1;
        end
    end

    // Saturating event counters, cleared only by reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall)  r_stall_cnt <= sat_inc(r_stall_cnt);
            if (w_pc_src) r_flush_cnt <= sat_inc(r_flush_cnt);
        end
    end

    pipe_fwd_unit #(
        .REG_AW (REG_AW)
    ) u_fwd (
        .i_ex_rs        (r_rs_p0),
        .i_ex_rt        (r_rt_p0),
        .i_mem_RegWrite (r_RegWrite_p1),
        .i_mem_dst      (r_dst_p1),
        .i_wb_RegWrite  (r_RegWrite_p2),
        .i_wb_dst       (r_dst_p2),
        .o_fwdA         (w_fwdA),
        .o_fwdB         (w_fwdB)
    );

    assign bus.stall        = w_stall;
    assign bus.flush_ifid   = w_pc_src;
    assign bus.pc_src       = w_pc_src;
    assign bus.ex_ALUSrc    = r_ALUSrc_p0;
    assign bus.ex_ALUcntrl  = r_ALUcntrl_p0;
    assign bus.ex_rs        = r_rs_p0;
    assign bus.ex_rt        = r_rt_p0;
    assign bus.mem_MemRead  = r_MemRead_p1;
    assign bus.mem_MemWrite = r_MemWrite_p1;
    assign bus.wb_RegWrite  = r_RegWrite_p2;
    assign bus.wb_MemToReg  = r_MemToReg_p2;
    assign bus.wb_dst       = r_dst_p2;
    assign bus.fwdA         = w_fwdA;
    assign bus.fwdB         = w_fwdB;
    assign bus.stall_cnt    = r_stall_cnt;
    assign bus.flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl_tracker.sv
// Directed bench for pipe_ctrl_tracker: one instance with 16-bit counters and
// one with 2-bit counters, both fed the same instruction stream.
module tb_pipe_ctrl_tracker;
    import pipe_ctrl_tracker_pkg::*;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;

    pipe_ctrl_tracker_if #(.REG_AW(5), .CNT_W(16)) b16 ();
    pipe_ctrl_tracker_if #(.REG_AW(5), .CNT_W(2))  b2 ();

    pipe_ctrl_tracker #(.REG_AW(5), .CNT_W(16)) dut16 (
        .clock (clock),
        .reset (reset),
        .bus   (b16)
    );

    pipe_ctrl_tracker #(.REG_AW(5), .CNT_W(2)) dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (b2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_id(input logic regdst, input logic branch, input logic bne,
                          input logic memrd, input logic memwr, input logic memtoreg,
                          input logic alusrc, input logic regwr, input logic [1:0] alu,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        b16.id_RegDst = regdst;   b2.id_RegDst = regdst;
        b16.id_Branch = branch;   b2.id_Branch = branch;
        b16.id_bne = bne;         b2.id_bne = bne;
        b16.id_MemRead = memrd;   b2.id_MemRead = memrd;
        b16.id_MemWrite = memwr;  b2.id_MemWrite = memwr;
        b16.id_MemToReg = memtoreg; b2.id_MemToReg = memtoreg;
        b16.id_ALUSrc = alusrc;   b2.id_ALUSrc = alusrc;
        b16.id_RegWrite = regwr;  b2.id_RegWrite = regwr;
        b16.id_ALUcntrl = alu;    b2.id_ALUcntrl = alu;
        b16.id_rs = rs;           b2.id_rs = rs;
        b16.id_rt = rt;           b2.id_rt = rt;
        b16.id_rd = rd;           b2.id_rd = rd;
    endtask

    task automatic rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        set_id(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_RTYPE, rs, rt, rd);
    endtask

    task automatic lw(input logic [4:0] base, input logic [4:0] rt);
        set_id(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, ALU_ADD, base, rt, 5'd0);
    endtask

    task automatic sw(input logic [4:0] base, input logic [4:0] rt);
        set_id(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ALU_ADD, base, rt, 5'd0);
    endtask

    task automatic br(input logic [4:0] rs, input logic [4:0] rt, input logic bne);
        set_id(1'b0, 1'b1, bne, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_SUB, rs, rt, 5'd0);
    endtask

    task automatic nop();
        set_id(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic set_zero(input logic z);
        b16.ex_Zero = z;
        b2.ex_Zero  = z;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({b16.stall, b16.flush_ifid, b16.pc_src, b16.ex_ALUSrc, b16.ex_ALUcntrl,
                    b16.ex_rs, b16.ex_rt, b16.mem_MemRead, b16.mem_MemWrite,
                    b16.wb_RegWrite, b16.wb_MemToReg, b16.wb_dst, b16.fwdA, b16.fwdB});
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        set_zero(1'b0);
        rtype(5'd1, 5'd2, 5'd3);               // add $3,$1,$2 held in ID during reset
        tick();
        tick();
        settle();
        check("reset_outs", all_outs(), 32'd0);
        check("reset_cnt16", 32'({b16.stall_cnt, b16.flush_cnt}), 32'd0);
        check("reset_cnt2", 32'({b2.stall_cnt, b2.flush_cnt}), 32'd0);

        reset = 1'b1;
        tick();                                // EX = add $3,$1,$2
        rtype(5'd3, 5'd1, 5'd4);               // sub $4,$3,$1
        settle();
        check("rel_ex_ctrl", 32'({b16.ex_ALUSrc, b16.ex_ALUcntrl, b16.ex_rs, b16.ex_rt}),
              32'({1'b0, 2'b10, 5'd1, 5'd2}));
        tick();
        nop();
        settle();
        check("fwd_exmem_A", 32'(b16.fwdA), 32'(FWD_MEM));
        check("fwd_exmem_B", 32'(b16.fwdB), 32'(FWD_REG));
        tick();
        rtype(5'd1, 5'd2, 5'd3);               // add $3,$1,$2 again
        settle();
        check("wb_latency", 32'({b16.wb_RegWrite, b16.wb_MemToReg, b16.wb_dst}),
              32'({1'b1, 1'b0, 5'd3}));
        tick();
        nop();
        tick();
        rtype(5'd3, 5'd1, 5'd4);
        tick();
        nop();
        settle();
        check("fwd_memwb_A", 32'(b16.fwdA), 32'(FWD_WB));
        check("fwd_memwb_B", 32'(b16.fwdB), 32'(FWD_REG));

        tick();
        rtype(5'd1, 5'd2, 5'd3);
        tick();
        rtype(5'd2, 5'd2, 5'd3);
        tick();
        rtype(5'd3, 5'd3, 5'd4);
        tick();
        nop();
        settle();
        check("fwd_prio", 32'({b16.fwdA, b16.fwdB}), 32'({FWD_MEM, FWD_MEM}));

        // load-use
        tick();
        lw(5'd1, 5'd5);
        tick();
        rtype(5'd5, 5'd2, 5'd6);
        settle();
        check("lu_stall", 32'({b16.stall, b16.flush_ifid}), 32'({1'b1, 1'b0}));
        tick();                                // ID held, EX bubble
        settle();
        check("lu_bubble", 32'({b16.stall, b16.ex_ALUcntrl, b16.ex_rs, b16.ex_rt, b16.mem_MemRead}),
              32'({1'b0, 2'b00, 5'd0, 5'd0, 1'b1}));
        check("lu_cnt", 32'(b16.stall_cnt), 32'd1);
        tick();
        nop();
        settle();
        check("lu_fwd", 32'({b16.fwdA, b16.fwdB, b16.ex_rs}), 32'({FWD_WB, FWD_REG, 5'd5}));
        check("lu_wb", 32'({b16.wb_MemToReg, b16.wb_dst}), 32'({1'b1, 5'd5}));

        // beq taken
        tick();
        br(5'd1, 5'd2, 1'b0);
        tick();
        rtype(5'd1, 5'd2, 5'd9);
        set_zero(1'b1);
        settle();
        check("beq_taken", 32'({b16.pc_src, b16.flush_ifid, b16.stall}), 32'({1'b1, 1'b1, 1'b0}));
        tick();
        nop();
        set_zero(1'b0);
        settle();
        check("beq_bubble", 32'({b16.pc_src, b16.ex_ALUcntrl, b16.ex_rs, b16.ex_rt}), 32'd0);
        check("beq_fcnt", 32'(b16.flush_cnt), 32'd1);

        // beq not taken
        tick();
        br(5'd1, 5'd2, 1'b0);
        tick();
        rtype(5'd1, 5'd2, 5'd9);
        set_zero(1'b0);
        settle();
        check("beq_nt", 32'({b16.pc_src, b16.flush_ifid}), 32'd0);
        tick();
        nop();
        settle();
        check("beq_nt_ex", 32'({b16.ex_ALUcntrl, b16.ex_rs, b16.ex_rt}), 32'({2'b10, 5'd1, 5'd2}));
        check("beq_nt_fcnt", 32'(b16.flush_cnt), 32'd1);

        // reset mid-operation: a store in EX must not reach MEM
        tick();
        sw(5'd2, 5'd7);
        tick();
        reset = 1'b0;
        tick();
        settle();
        check("rst_mid_outs", all_outs(), 32'd0);
        check("rst_mid_cnt", 32'({b16.stall_cnt, b16.flush_cnt}), 32'd0);
        tick();
        reset = 1'b1;
        // branch carrying a load-like EX dst: bne must win over load-use
        set_id(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_SUB, 5'd1, 5'd5, 5'd0);
        tick();
        rtype(5'd5, 5'd2, 5'd6);
        set_zero(1'b0);
        settle();
        check("bne_prio", 32'({b16.pc_src, b16.stall, b16.flush_ifid}), 32'({1'b1, 1'b0, 1'b1}));
        tick();
        nop();
        settle();
        check("bne_cnts", 32'({b16.flush_cnt, b16.stall_cnt}), 32'({16'd1, 16'd0}));
        check("bne_bubble", 32'(b16.ex_rs), 32'd0);

        // $0 is never a hazard or forwarding source
        tick();
        lw(5'd1, 5'd0);
        tick();
        rtype(5'd0, 5'd2, 5'd6);
        settle();
        check("r0_nostall", 32'(b16.stall), 32'd0);
        tick();
        nop();
        settle();
        check("r0_nofwd", 32'({b16.mem_MemRead, b16.fwdA}), 32'({1'b1, FWD_REG}));

        // five load-use stalls
        for (int i = 0; i < 5; i++) begin
            tick();
            lw(5'd1, 5'd5);
            tick();
            rtype(5'd5, 5'd2, 5'd6);
            settle();
            check($sformatf("sat_stall%0d", i), 32'(b16.stall), 32'd1);
            tick();
        end
        tick();
        nop();
        settle();
        check("sat_cnt2", 32'(b2.stall_cnt), 32'd3);
        check("sat_cnt16", 32'(b16.stall_cnt), 32'd5);
        check("sat_fcnt2", 32'(b2.flush_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
